baud_gen_frac: RTL and testbench
================================

# baud_gen_frac

Programmable fractional baud-rate generator for the UART IP, the parametrised successor to the fixed-select BRG. It divides `fclk` by a run-time integer+fractional divisor to produce an oversample tick. A configurable oversample counter derives the bit tick, the sample phase and a bit-rate square wave. It feeds both the UART transmitter (`tick_bit`) and the receiver (`tick_os`, `os_phase`).

## Interface
- `DIV_W`, 16: width of integer divisor.
- `FRAC_W`, 4: width of fractional divisor; fraction = `div_frac`/2^FRAC_W.
- `OSR`, 16: oversample ratio; power of two, 4..32.
- `DEF_INT`, 27: active integer divisor after reset (must be ≥2).
- `DEF_FRAC`, 2: active fractional divisor after reset.
- `fclk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: run enable; low = generator idle and cleared.
- `div_int` in DIV_W: integer divisor, captured on `div_load`.
- `div_frac` in FRAC_W: fractional divisor, captured on `div_load`.
- `div_load` in 1: single-cycle strobe capturing `div_int`/`div_frac` into shadow.
- `cfg_pending` out 1: shadow captured but not yet active.
- `cfg_err` out 1: active `div_int` < 2.
- `tick_os` out 1: one-cycle oversample tick.
- `tick_bit` out 1: one-cycle bit tick, every OSR `tick_os`.
- `os_phase` out log2(OSR): oversample index within bit, 0..OSR-1.
- `bclk` out 1: bit-rate square wave, high while `os_phase` ≥ OSR/2.

## Operation
- Registers: active divisor (`act_int`, `act_frac`), shadow, cycle counter `cnt` (DIV_W+1), fractional accumulator `acc` (FRAC_W), `ext` (period-extend flag), `os_phase`.
- States:
  - IDLE (`en`=0 or `cfg_err`): `cnt`, `acc`, `ext`, `os_phase` held at 0; `tick_os`/`tick_bit`/`bclk` = 0.
  - RUN: `en`=1 and `act_int` ≥ 2.
- Period length L = `act_int` + `ext`. In RUN, `cnt` increments each cycle. When `cnt` = L-1:
  - `cnt` ← 0 and `tick_os` registered high for one cycle.
  - `{carry, acc}` ← `acc` + `act_frac`; `ext` ← carry for the next period.
- The first period after entering RUN always has `ext`=0. Average period = `act_int` + `act_frac`/2^FRAC_W cycles.
- On each tick, `os_phase` ← `os_phase`+1 mod OSR. `tick_bit` is high on the tick where `os_phase` wraps OSR-1→0.
- `bclk` is a register updated together with `os_phase`: high when new `os_phase` ≥ OSR/2.
- Configuration:
  - `div_load` writes the shadow and sets `cfg_pending`.
  - Shadow → active on the cycle a tick is generated, so it governs the next period. `acc`/`ext`/`os_phase` are not reset by this.
  - In IDLE, shadow → active on the cycle after `div_load`.
  - `div_load` coincident with a tick-generating edge: the new values bypass directly to active for the next period, and `cfg_pending` stays 0.
  - A second `div_load` while pending overwrites the shadow.
- `cfg_err` is combinational from `act_int`. While set, the block is in IDLE; it recovers via `div_load` of a legal value, applied through the IDLE path.

## Timing
- Reset (async assert, sync-safe deassert):
  - `act_int`=DEF_INT, `act_frac`=DEF_FRAC, shadow = same.
  - `cfg_pending`=0, `cnt`=`acc`=`ext`=`os_phase`=0.
  - `tick_os`=`tick_bit`=`bclk`=0.
- `en` sampled high at edge k (integer divisor D): `tick_os` high in cycles k+D, k+2D, … (outputs registered).
- `en` low at edge j: at edge j all counters clear and outputs are 0 from that cycle. An in-flight period is discarded, with no partial tick.
- Reset mid-operation: same as power-up. A pending shadow is lost.
- `tick_bit` ⊂ `tick_os`; the two are coincident.
- `bclk` toggles only on `tick_os` edges.

## Test plan
- Reset defaults, `en`=1, OSR=16: `tick_os` periods 27,27,27,27,27,27,27,28 repeating; mean 27.125; `tick_bit` every 16 ticks.
- `div_load` `div_int`=4, `div_frac`=8, FRAC_W=4, from IDLE, then `en`=1: tick periods 4,4,5,4,5,4,5; `cfg_pending` high exactly one cycle.
- RUN with D=10, `div_load` D=6 mid-period: current period completes at 10. The next period is 6. `cfg_pending` falls on that tick. `os_phase` continues without reset.
- `div_load` on the same edge as a tick: the next period already uses the new value, and `cfg_pending` never asserts.
- `div_load` `div_int`=1: `cfg_err`=1, no ticks, outputs 0. Then `div_load` 3: `cfg_err` clears and ticks resume every 3 cycles.
- `en` dropped at `os_phase`=9 mid-period, and separately `rst_n` pulsed: `os_phase`=0, `bclk`=0, no tick. After re-enable, the first tick comes exactly `act_int` cycles later.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: divides fclk by act_int + act_frac/2^FRAC_W
// to make an oversample tick. It also derives the bit tick, the oversample
// phase and a bit-rate square wave. Divisor updates go through a shadow
// register so that a running period is never cut short.
module baud_gen_frac #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16,
  parameter int DEF_INT  = 27,
  parameter int DEF_FRAC = 2
) (
  input  logic                    fclk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [DIV_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  input  logic                    div_load,
  output logic                    cfg_pending,
  output logic                    cfg_err,
  output logic                    tick_os,
  output logic                    tick_bit,
  output logic [$clog2(OSR)-1:0]  os_phase,
  output logic                    bclk
);

  localparam int PH_W = $clog2(OSR);

  typedef enum logic {IDLE, RUN} mode_t;

  mode_t               mode;
  logic [DIV_W-1:0]    act_int;
  logic [DIV_W-1:0]    sh_int;
  logic [FRAC_W-1:0]   act_frac;
  logic [FRAC_W-1:0]   sh_frac;
  logic [DIV_W:0]      cnt;
  logic [FRAC_W-1:0]   acc;
  logic                ext;
  logic                tick_gen;
  logic [FRAC_W:0]     acc_sum;
  logic [PH_W-1:0]     phase_nxt;

  // Terminal count of a period of length d + e (one wider so d + 1 cannot overflow).
  function automatic logic [DIV_W:0] last_count(input logic [DIV_W-1:0] d, input logic e);
    return {1'b0, d} + (DIV_W+1)'(e) - (DIV_W+1)'(1);
  endfunction

  // bclk is high for the second half of the oversample phases.
  function automatic logic upper_half(input logic [PH_W-1:0] p);
    return p >= PH_W'(OSR/2);
  endfunction

  assign cfg_err   = (act_int < DIV_W'(2));
  assign acc_sum   = {1'b0, acc} + {1'b0, act_frac};
  assign phase_nxt = os_phase + PH_W'(1);

  // Mode decode: the generator only runs while enabled with a legal divisor.
  always_comb begin
    mode     = IDLE;
    tick_gen = 1'b0;
    if (en && !cfg_err) begin
      mode     = RUN;
      tick_gen = (cnt == last_count(act_int, ext));
    end
  end

  // Period counter, fractional accumulator, oversample phase and registered outputs.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      ext      <= 1'b0;
      os_phase <= '0;
      tick_os  <= 1'b0;
      tick_bit <= 1'b0;
      bclk     <= 1'b0;
    end else if (mode == IDLE) begin
      // Idle discards any partial period so the next start is a clean full one.
      cnt      <= '0;
      acc      <= '0;
      ext      <= 1'b0;
      os_phase <= '0;
      tick_os  <= 1'b0;
      tick_bit <= 1'b0;
      bclk     <= 1'b0;
    end else begin
      tick_os  <= tick_gen;
      tick_bit <= tick_gen && (os_phase == PH_W'(OSR-1));
      if (tick_gen) begin
        cnt      <= '0;
        acc      <= acc_sum[FRAC_W-1:0];
        ext      <= acc_sum[FRAC_W];
        os_phase <= phase_nxt;
        bclk     <= upper_half(phase_nxt);
      end else begin
        cnt <= cnt + (DIV_W+1)'(1);
      end
    end
  end

  // Divisor shadow/active handling; a load on a tick edge bypasses the shadow.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      act_int     <= DIV_W'(DEF_INT);
      act_frac    <= FRAC_W'(DEF_FRAC);
      sh_int      <= DIV_W'(DEF_INT);
      sh_frac     <= FRAC_W'(DEF_FRAC);
      cfg_pending <= 1'b0;
    end else if (div_load && tick_gen) begin
      act_int     <= div_int;
      act_frac    <= div_frac;
      sh_int      <= div_int;
      sh_frac     <= div_frac;
      cfg_pending <= 1'b0;
    end else if (div_load) begin
      sh_int      <= div_int;
      sh_frac     <= div_frac;
      cfg_pending <= 1'b1;
    end else if (cfg_pending && (tick_gen || mode == IDLE)) begin
      act_int     <= sh_int;
      act_frac    <= sh_frac;
      cfg_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: a tick-schedule reference model in the
// driver pushes expected per-edge status and tick records; an independent
// monitor pops and compares them against the DUT outputs.
module tb_baud_gen_frac;

  localparam int DIV_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int OSR      = 16;
  localparam int DEF_INT  = 27;
  localparam int DEF_FRAC = 2;
  localparam int ACC_MOD  = 1 << FRAC_W;

  logic              fclk;
  logic              rst_n;
  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              cfg_pending;
  logic              cfg_err;
  logic              tick_os;
  logic              tick_bit;
  logic [3:0]        os_phase;
  logic              bclk;

  baud_gen_frac #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR), .DEF_INT(DEF_INT), .DEF_FRAC(DEF_FRAC)
  ) dut (
    .fclk(fclk), .rst_n(rst_n), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .tick_os(tick_os), .tick_bit(tick_bit), .os_phase(os_phase), .bclk(bclk)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  typedef struct {
    int cyc;
    int phase;
    bit tbit;
    bit bclk_e;
  } tick_t;

  typedef struct {
    int cyc;
    bit pend;
    bit err;
    bit tick;
    bit tbit;
    bit bclk_e;
    int phase;
  } stat_t;

  tick_t tq[$];
  stat_t sq[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state (driver-owned).
  int n      = 0;
  int sched  = -1;
  int m_int  = DEF_INT;
  int m_frac = DEF_FRAC;
  int s_int  = DEF_INT;
  int s_frac = DEF_FRAC;
  int m_acc  = 0;
  int m_phase = 0;
  bit pend   = 0;

  bit cur_rst = 0;
  bit cur_en  = 0;

  task automatic chk(input string nm, input int act, input int exp, input int cyc);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Model of one clock edge: ticks are scheduled as absolute edge numbers.
  task automatic model_edge(input bit r, input bit e, input bit ld, input int di, input int df);
    bit run, tick, carry;
    stat_t st;
    tick_t te;
    n++;
    tick = 0;
    if (!r) begin
      m_int = DEF_INT; m_frac = DEF_FRAC; s_int = DEF_INT; s_frac = DEF_FRAC;
      pend = 0; m_acc = 0; m_phase = 0; sched = -1;
    end else begin
      run = e && (m_int >= 2);
      if (!run) begin
        sched = -1; m_acc = 0; m_phase = 0;
      end else begin
        if (sched < 0) sched = n + m_int - 1;
        tick = (n == sched);
      end
      if (tick) begin
        carry   = (m_acc + m_frac) >= ACC_MOD;
        m_acc   = (m_acc + m_frac) % ACC_MOD;
        m_phase = (m_phase + 1) % OSR;
        te.cyc = n; te.phase = m_phase; te.tbit = (m_phase == 0); te.bclk_e = (m_phase >= OSR/2);
        tq.push_back(te);
        if (ld) begin
          m_int = di; m_frac = df; s_int = di; s_frac = df; pend = 0;
        end else if (pend) begin
          m_int = s_int; m_frac = s_frac; pend = 0;
        end
        sched = n + m_int + int'(carry);
      end else if (ld) begin
        s_int = di; s_frac = df; pend = 1;
      end else if (!run && pend) begin
        m_int = s_int; m_frac = s_frac; pend = 0;
      end
    end
    st.cyc = n; st.pend = pend; st.err = (m_int < 2); st.tick = tick;
    st.tbit = tick && (m_phase == 0); st.phase = m_phase; st.bclk_e = (m_phase >= OSR/2);
    sq.push_back(st);
  endtask

  task automatic step(input bit ld, input int di, input int df);
    @(negedge fclk);
    rst_n    = cur_rst;
    en       = cur_en;
    div_load = ld;
    div_int  = DIV_W'(di);
    div_frac = FRAC_W'(df);
    @(posedge fclk);
    model_edge(cur_rst, cur_en, ld, di, df);
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 0, 0);
  endtask

  // Monitor: compares every edge's status and matches each DUT tick to the tick queue.
  initial begin
    stat_t st;
    tick_t te;
    forever begin
      @(posedge fclk);
      #1;
      if (sq.size() > 0) begin
        st = sq.pop_front();
        chk("cfg_pending", int'(cfg_pending), int'(st.pend), st.cyc);
        chk("cfg_err", int'(cfg_err), int'(st.err), st.cyc);
        chk("tick_os", int'(tick_os), int'(st.tick), st.cyc);
        chk("tick_bit", int'(tick_bit), int'(st.tbit), st.cyc);
        chk("os_phase", int'(os_phase), st.phase, st.cyc);
        chk("bclk", int'(bclk), int'(st.bclk_e), st.cyc);
        while (tq.size() > 0 && tq[0].cyc < st.cyc) begin
          te = tq.pop_front();
          chk("tick_missed", 0, 1, te.cyc);
        end
        if (tick_os) begin
          if (tq.size() > 0 && tq[0].cyc == st.cyc) begin
            te = tq.pop_front();
            chk("tick_phase", int'(os_phase), te.phase, st.cyc);
            chk("tick_bit_at_tick", int'(tick_bit), int'(te.tbit), st.cyc);
            chk("bclk_at_tick", int'(bclk), int'(te.bclk_e), st.cyc);
          end else begin
            chk("tick_unexpected", 1, 0, st.cyc);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;
    cur_rst = 0; cur_en = 0;
    idle_steps(3);
    cur_rst = 1;
    idle_steps(2);

    // Default divisor 27 + 2/16: tick_bit after 16 ticks.
    cur_en = 1;
    idle_steps(27 * 18);

    // Load 4 + 8/16 from idle, then run.
    cur_en = 0;
    step(1'b1, 4, 8);
    idle_steps(2);
    cur_en = 1;
    idle_steps(40);

    // Switch to 10, then load 6 in the middle of a period.
    step(1'b1, 10, 0);
    idle_steps(25);
    for (int i = 0; i < 40 && (sched - n) != 5; i++) step(1'b0, 0, 0);
    step(1'b1, 6, 0);
    idle_steps(30);

    // Load exactly on a tick-generating edge.
    for (int i = 0; i < 40 && sched != n + 1; i++) step(1'b0, 0, 0);
    step(1'b1, 7, 3);
    idle_steps(40);

    // Illegal divisor, then recovery with 3.
    step(1'b1, 1, 0);
    idle_steps(30);
    step(1'b1, 3, 0);
    idle_steps(20);

    // Drop enable at os_phase 9 mid-period, then re-enable.
    for (int i = 0; i < 200 && !(m_phase == 9 && sched > n + 1); i++) step(1'b0, 0, 0);
    cur_en = 0;
    idle_steps(4);
    cur_en = 1;
    idle_steps(30);

    // Reset pulse with a pending shadow.
    step(1'b1, 9, 5);
    cur_rst = 0;
    idle_steps(2);
    cur_rst = 1;
    idle_steps(60);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      bit ld;
      int di;
      int df;
      if ($urandom_range(0, 149) == 0) cur_en = !cur_en;
      if (!cur_en && $urandom_range(0, 19) == 0) cur_en = 1;
      cur_rst = ($urandom_range(0, 799) != 0);
      ld = ($urandom_range(0, 59) == 0) || (sched == n + 1 && $urandom_range(0, 3) == 0);
      di = $urandom_range(0, 12);
      df = $urandom_range(0, 15);
      step(ld, di, df);
    end
    cur_rst = 1;
    idle_steps(2);

    repeat (3) @(posedge fclk);
    #2;
    chk("tick_queue_drained", tq.size(), 0, n);
    chk("status_queue_drained", sq.size(), 0, n);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
